// File: rtl/arb_pkg.sv
// rtl/arb_pkg.sv - shared constants and helpers for the round-robin resource arbiter
package arb_pkg;

    localparam int ARB_MAX_N = 16;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_OWNED = 1'b1
    } arb_state_e;

    function automatic logic [ARB_MAX_N-1:0] onehot_of(input int unsigned idx, input int unsigned n);
        logic [ARB_MAX_N-1:0] v;
        v = '0;
        if (idx < n) begin
            v = ARB_MAX_N'(1) << idx;
        end
        return v;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational round-robin picker: first set request after last_ptr, cyclically
module rr_pick
    import arb_pkg::*;
#(
    parameter int N   = 4,
    parameter int IDW = $clog2(N)
) (
    input  logic [N-1:0]   req_i,
    input  logic [IDW-1:0] last_ptr_i,
    output logic           any_o,
    output logic [IDW-1:0] pick_idx_o
);

    assign any_o = |req_i;

    // Walk the rotated order backwards so the last hit is the nearest one after last_ptr.
    always_comb begin
        pick_idx_o = '0;
        for (int i = N - 1; i >= 0; i--) begin
            int j;
            j = (int'(last_ptr_i) + 1 + i) % N;
            if (req_i[j]) begin
                pick_idx_o = IDW'(j);
            end
        end
    end

endmodule

// File: rtl/rr_resource_arbiter.sv
// rtl/rr_resource_arbiter.sv - round-robin owner arbiter with release, withdraw and hold-time limit
module rr_resource_arbiter
    import arb_pkg::*;
#(
    parameter int  N        = 4,
    parameter int  HOLD_MAX = 8,
    localparam int IDW      = $clog2(N)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [N-1:0]   req,
    input  logic           done,
    output logic [N-1:0]   grant,
    output logic [IDW-1:0] grant_id,
    output logic           busy,
    output logic           timeout
);

    localparam int HCW = (HOLD_MAX < 1) ? 1 : $clog2(HOLD_MAX + 1);

    arb_state_e     state_q, state_d;
    logic [HCW-1:0] hold_cnt_q, hold_cnt_d;
    logic [IDW-1:0] last_ptr_q, last_ptr_d;
    logic [N-1:0]   grant_q, grant_d;
    logic [IDW-1:0] grant_id_q, grant_id_d;
    logic           timeout_q, timeout_d;

    logic           any_req;
    logic [IDW-1:0] pick_idx;
    logic [ARB_MAX_N-1:0] pick_oh;
    logic           rel_done, rel_wd, rel_lim;

    rr_pick #(.N(N), .IDW(IDW)) u_pick (
        .req_i      (req),
        .last_ptr_i (last_ptr_q),
        .any_o      (any_req),
        .pick_idx_o (pick_idx)
    );

    assign pick_oh  = onehot_of(int'(pick_idx), N);
    assign rel_done = done;
    assign rel_wd   = ~req[grant_id_q];
    assign rel_lim  = (HOLD_MAX != 0) && (hold_cnt_q == HCW'(HOLD_MAX));

    always_comb begin
        state_d    = state_q;
        hold_cnt_d = hold_cnt_q;
        last_ptr_d = last_ptr_q;
        grant_d    = grant_q;
        grant_id_d = grant_id_q;
        timeout_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (any_req) begin
                    state_d    = ST_OWNED;
                    grant_d    = pick_oh[N-1:0];
                    grant_id_d = pick_idx;
                    last_ptr_d = pick_idx;
                    hold_cnt_d = HCW'(1);
                end
            end
            ST_OWNED: begin
                if (rel_done || rel_wd || rel_lim) begin
                    state_d   = ST_IDLE;
                    grant_d   = '0;
                    // Only a pure limit expiry is reported; a voluntary release wins a tie.
                    timeout_d = rel_lim && !rel_done && !rel_wd;
                end else if ((HOLD_MAX != 0) && (hold_cnt_q < HCW'(HOLD_MAX))) begin
                    hold_cnt_d = hold_cnt_q + HCW'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            hold_cnt_q <= '0;
            last_ptr_q <= IDW'(N - 1);
            grant_q    <= '0;
            grant_id_q <= '0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            hold_cnt_q <= hold_cnt_d;
            last_ptr_q <= last_ptr_d;
            grant_q    <= grant_d;
            grant_id_q <= grant_id_d;
            timeout_q  <= timeout_d;
        end
    end

    assign grant    = grant_q;
    assign grant_id = grant_id_q;
    assign busy     = |grant_q;
    assign timeout  = timeout_q;

endmodule
